// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: 2-entry skid buffer between a valid/ready
// upstream and the FIFO write port, plus wrapping write and saturating stall counters.
module wr_ingress_ctrl #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_SIZE  = 16
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  input  logic                 wfull,
  output logic                 wr_en,
  output logic [DATA_SIZE-1:0] wdata,
  input  logic                 cnt_clr,
  output logic [CNT_SIZE-1:0]  wr_count,
  output logic [CNT_SIZE-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic [CNT_SIZE-1:0]  wr_count_q, wr_count_d;
  logic [CNT_SIZE-1:0]  stall_count_q, stall_count_d;
  logic                 accept, drain;

  always_comb begin
    s_ready = (state_q != TWO);
    wr_en   = (state_q != EMPTY) && !wfull;
    accept  = s_valid && s_ready;
    drain   = wr_en;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = s_data;
          state_d = ONE;
        end
      end
      ONE: begin
        // Accept+drain together overwrites the head: the old head leaves this edge.
        case ({accept, drain})
          2'b10: begin
            tail_d  = s_data;
            state_d = TWO;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d  = s_data;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    if (cnt_clr) begin
      wr_count_d    = '0;
      stall_count_d = '0;
    end else begin
      if (drain)
        wr_count_d = wr_count_q + CNT_SIZE'(1);
      if ((state_q != EMPTY) && wfull && (stall_count_q != '1))
        stall_count_d = stall_count_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q       <= EMPTY;
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_ff @(posedge wr_clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign wdata       = head_q;
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Bench for wr_ingress_ctrl: a queue/arithmetic model checked every cycle against a
// default-width instance and a 4-bit-counter instance, plus directed literal checks.
module tb_wr_ingress_ctrl;

  logic       wr_clk = 1'b0;
  logic       wr_rst, s_valid, wfull, cnt_clr;
  logic [7:0] s_data;

  logic        s_ready, wr_en;
  logic [7:0]  wdata;
  logic [15:0] wr_count, stall_count;

  logic        s_ready_n, wr_en_n;
  logic [7:0]  wdata_n;
  logic [3:0]  wr_count_n, stall_count_n;

  wr_ingress_ctrl #(.DATA_SIZE(8), .CNT_SIZE(16)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wfull(wfull), .wr_en(wr_en), .wdata(wdata),
    .cnt_clr(cnt_clr), .wr_count(wr_count), .stall_count(stall_count)
  );

  wr_ingress_ctrl #(.DATA_SIZE(8), .CNT_SIZE(4)) dut_n (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_n), .wfull(wfull), .wr_en(wr_en_n), .wdata(wdata_n),
    .cnt_clr(cnt_clr), .wr_count(wr_count_n), .stall_count(stall_count_n)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic [7:0] m_q[$];
  int m_wr = 0, m_st = 0, m_wrn = 0, m_stn = 0;

  logic [7:0] wlog[$];
  int         wcyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // Reference model: FIFO of at most two words and plain integer counters.
  always @(posedge wr_clk) begin
    bit acc, drn, stl;
    cyc++;
    if (wr_rst) begin
      m_q.delete();
      m_wr = 0; m_st = 0; m_wrn = 0; m_stn = 0;
    end else begin
      acc = s_valid && (m_q.size() < 2);
      drn = (m_q.size() > 0) && !wfull;
      stl = (m_q.size() > 0) && wfull;
      if (cnt_clr) begin
        m_wr = 0; m_st = 0; m_wrn = 0; m_stn = 0;
      end else begin
        if (drn) begin
          m_wr  = (m_wr + 1) % 65536;
          m_wrn = (m_wrn + 1) % 16;
        end
        if (stl && m_st < 65535) m_st++;
        if (stl && m_stn < 15) m_stn++;
      end
      if (drn) void'(m_q.pop_front());
      if (acc) m_q.push_back(s_data);
    end
  end

  always @(negedge wr_clk) begin
    if (chk_en) begin
      check("s_ready", {31'd0, s_ready}, {31'd0, m_q.size() < 2});
      check("wr_en", {31'd0, wr_en}, {31'd0, (m_q.size() > 0) && !wfull});
      if (m_q.size() > 0) check("wdata", {24'd0, wdata}, {24'd0, m_q[0]});
      check("wr_count", {16'd0, wr_count}, m_wr);
      check("stall_count", {16'd0, stall_count}, m_st);
      check("s_ready_n", {31'd0, s_ready_n}, {31'd0, m_q.size() < 2});
      check("wr_en_n", {31'd0, wr_en_n}, {31'd0, (m_q.size() > 0) && !wfull});
      if (m_q.size() > 0) check("wdata_n", {24'd0, wdata_n}, {24'd0, m_q[0]});
      check("wr_count_n", {28'd0, wr_count_n}, m_wrn);
      check("stall_count_n", {28'd0, stall_count_n}, m_stn);
      if (wr_en) begin
        wlog.push_back(wdata);
        wcyc.push_back(cyc);
      end
    end
  end

  initial begin
    int c0;
    wr_rst = 1'b1; s_valid = 1'b0; s_data = '0; wfull = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_stall_count", {16'd0, stall_count}, 32'd0);
    wr_rst = 1'b0;
    tick();

    // Streaming 0x01..0x10 back-to-back
    wlog.delete(); wcyc.delete();
    s_valid = 1'b1;
    c0 = 0;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      tick();
      if (i == 1) c0 = cyc;
    end
    s_valid = 1'b0;
    repeat (3) tick();
    check("stream_nwords", wlog.size(), 32'd16);
    if (wlog.size() == 16) begin
      for (int i = 0; i < 16; i++) check("stream_word", {24'd0, wlog[i]}, 32'(i + 1));
      check("stream_first_cycle", wcyc[0], c0);
      check("stream_contiguous", wcyc[15] - wcyc[0], 32'd15);
    end
    check("stream_wr_count", {16'd0, wr_count}, 32'd16);
    check("stream_wr_count_wrap4", {28'd0, wr_count_n}, 32'd0);

    // Accept and drain together while holding one word
    wlog.delete();
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(8'hC0 + i);
      tick();
      check("ad_s_ready", {31'd0, s_ready}, 32'd1);
      check("ad_wr_en", {31'd0, wr_en}, 32'd1);
      check("ad_head", {24'd0, wdata}, 32'(8'hC0 + i));
    end
    s_valid = 1'b0;
    repeat (2) tick();
    check("ad_nwords", wlog.size(), 32'd8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) check("ad_order", {24'd0, wlog[i]}, 32'(8'hC0 + i));

    // Backpressure: 0xA5 held while wfull, 0x5A skids into second slot
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    tick();
    s_data = 8'h5A;
    repeat (5) tick();
    check("bp_s_ready", {31'd0, s_ready}, 32'd0);
    check("bp_wr_en", {31'd0, wr_en}, 32'd0);
    check("bp_stall", {16'd0, stall_count}, 32'd5);
    check("bp_wdata", {24'd0, wdata}, 32'h0000_00A5);
    wlog.delete();
    s_valid = 1'b0; wfull = 1'b0;
    repeat (3) tick();
    check("bp_nwords", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      check("bp_first", {24'd0, wlog[0]}, 32'h0000_00A5);
      check("bp_second", {24'd0, wlog[1]}, 32'h0000_005A);
    end

    // Long stall: 4-bit counter saturates, 16-bit keeps counting
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    repeat (20) tick();
    check("sat_stall16", {16'd0, stall_count}, 32'd20);
    check("sat_stall4", {28'd0, stall_count_n}, 32'd15);
    wfull = 1'b0;
    repeat (2) tick();

    // cnt_clr on the same edge as a write
    s_valid = 1'b1; s_data = 8'h3C;
    tick();
    s_valid = 1'b0; cnt_clr = 1'b1;
    wlog.delete();
    tick();
    cnt_clr = 1'b0;
    check("clr_wr_count", {16'd0, wr_count}, 32'd0);
    check("clr_nwords", wlog.size(), 32'd1);
    if (wlog.size() == 1) check("clr_word", {24'd0, wlog[0]}, 32'h0000_003C);
    tick();
    check("clr_wr_count_after", {16'd0, wr_count}, 32'd0);

    // Reset while two words are buffered
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    check("two_s_ready", {31'd0, s_ready}, 32'd0);
    wr_rst = 1'b1; s_valid = 1'b0; wfull = 1'b0;
    tick();
    check("rst2_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst2_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst2_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst2_stall", {16'd0, stall_count}, 32'd0);
    wr_rst = 1'b0;
    repeat (2) tick();
    check("rst2_wr_en_later", {31'd0, wr_en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
